// File: rtl/ram_arbiter.sv
// ram_arbiter: grants the shared SRAM to the flash loader, the CPU or diagnostics.
// Also drives 6502 RDY through a halt/resume handshake aligned to phi2 falls.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi2,
  input  logic        rwbar,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_datain,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic        load_done,
  input  logic        flash_req,
  input  logic        flash_we,
  input  logic [15:0] flash_address,
  input  logic [7:0]  flash_datain,
  output logic        flash_ack,
  input  logic        diag_halt_req,
  output logic        diag_halt_ack,
  input  logic        diag_req,
  input  logic        diag_we,
  input  logic [15:0] diag_address,
  input  logic [7:0]  diag_datain,
  output logic        diag_ack,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_datain,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        rdy,
  output logic        data_oe,
  output logic        stalled
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_HALT_PEND,
    S_HALTED,
    S_RESUME_PEND
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           sync_q, sync_d;
  logic                 last_rd_q, last_rd_d;
  logic                 load_seen_q, load_seen_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 rdy_q, rdy_d;
  logic                 stalled_q, stalled_d;
  logic                 hack_q, hack_d;
  logic [1:0]           ph_q, ph_d;
  logic [15:0]          addr_q, addr_d;
  logic [7:0]           din_q, din_d;
  logic                 cs_q, cs_d;
  logic                 we_q, we_d;
  logic                 fack_q, fack_d;
  logic                 dack_q, dack_d;

  logic        fall;
  logic        idle;
  logic        cpu_own;
  logic        load_eff;
  logic        own_req;
  logic        own_we;
  logic [15:0] own_addr;
  logic [7:0]  own_din;
  logic        can_accept;

  assign fall     = sync_q[2] & ~sync_q[1];
  assign idle     = (ph_q == 2'd0);
  assign load_eff = load_seen_q | load_done;
  assign cpu_own  = (state_q == S_RUN)
                  | (state_q == S_HALT_PEND)
                  | (state_q == S_RESUME_PEND);

  always_comb begin
    own_req  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_din  = '0;
    unique case (1'b1)
      (state_q == S_LOAD): begin
        own_req  = flash_req & ~load_eff;
        own_we   = flash_we;
        own_addr = flash_address;
        own_din  = flash_datain;
      end
      (state_q == S_HALTED): begin
        own_req  = diag_req & diag_halt_req;
        own_we   = diag_we;
        own_addr = diag_address;
        own_din  = diag_datain;
      end
      default: own_req = 1'b0;
    endcase
  end

  assign can_accept = idle & own_req;

  always_comb begin
    sync_d      = {sync_q[1:0], phi2};
    last_rd_d   = fall ? rwbar : last_rd_q;
    load_seen_d = load_seen_q | load_done;
    state_d     = state_q;
    wd_d        = wd_q;
    rdy_d       = rdy_q;
    stalled_d   = stalled_q;
    hack_d      = hack_q;
    ph_d        = ph_q;
    addr_d      = addr_q;
    din_d       = din_q;
    cs_d        = 1'b0;
    we_d        = 1'b0;
    fack_d      = 1'b0;
    dack_d      = 1'b0;

    // Owned-access sequencer: strobe in N+1, ack in N+2.
    unique case (ph_q)
      2'd0: begin
        if (can_accept) begin
          ph_d   = 2'd1;
          cs_d   = 1'b1;
          we_d   = own_we;
          addr_d = own_addr;
          din_d  = own_din;
        end
      end
      2'd1: begin
        ph_d   = 2'd2;
        fack_d = (state_q == S_LOAD);
        dack_d = (state_q == S_HALTED);
      end
      default: begin
        ph_d   = 2'd0;
        addr_d = '0;
        din_d  = '0;
      end
    endcase

    unique case (state_q)
      S_LOAD: begin
        if (load_eff && idle) begin
          state_d   = S_RUN;
          rdy_d     = 1'b1;
          stalled_d = 1'b0;
        end
      end
      S_RUN: begin
        if (diag_halt_req) begin
          state_d = S_HALT_PEND;
          wd_d    = '0;
        end
      end
      S_HALT_PEND: begin
        wd_d = fall ? '0
                    : wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        if (!diag_halt_req) begin
          state_d = S_RESUME_PEND;
        end else if (fall) begin
          // First fall drops RDY; a later read fall means the CPU stopped.
          rdy_d = 1'b0;
          if (!rdy_q && last_rd_d) begin
            state_d = S_HALTED;
            hack_d  = 1'b1;
          end
        end else if (&wd_q) begin
          state_d   = S_HALTED;
          hack_d    = 1'b1;
          rdy_d     = 1'b0;
          stalled_d = 1'b1;
        end
      end
      S_HALTED: begin
        if (!diag_halt_req && idle) begin
          state_d = S_RESUME_PEND;
          hack_d  = 1'b0;
        end
      end
      S_RESUME_PEND: begin
        if (diag_halt_req) begin
          state_d = S_HALT_PEND;
          wd_d    = '0;
        end else if (fall) begin
          state_d   = S_RUN;
          rdy_d     = 1'b1;
          stalled_d = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      sync_q      <= '0;
      last_rd_q   <= 1'b0;
      load_seen_q <= 1'b0;
      wd_q        <= '0;
      rdy_q       <= 1'b0;
      stalled_q   <= 1'b0;
      hack_q      <= 1'b0;
      ph_q        <= 2'd0;
      addr_q      <= '0;
      din_q       <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      fack_q      <= 1'b0;
      dack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      last_rd_q   <= last_rd_d;
      load_seen_q <= load_seen_d;
      wd_q        <= wd_d;
      rdy_q       <= rdy_d;
      stalled_q   <= stalled_d;
      hack_q      <= hack_d;
      ph_q        <= ph_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      fack_q      <= fack_d;
      dack_q      <= dack_d;
    end
  end

  assign ram_address   = cpu_own ? cpu_address : addr_q;
  assign ram_datain    = cpu_own ? cpu_datain  : din_q;
  assign ram_cs        = cpu_own ? cpu_cs      : cs_q;
  assign ram_we        = cpu_own ? cpu_we      : we_q;
  assign data_oe       = cpu_own & cpu_cs & rwbar;
  assign rdy           = rdy_q;
  assign stalled       = stalled_q;
  assign diag_halt_ack = hack_q;
  assign flash_ack     = fack_q;
  assign diag_ack      = dack_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vector table, directed sequences and a randomized
// access stream checked against an SRAM reference model.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int TW = 4;
  localparam int L  = 48;

  logic        clk = 1'b0;
  logic        reset;
  logic        phi2, rwbar;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_datain;
  logic        cpu_cs, cpu_we, load_done;
  logic        flash_req, flash_we;
  logic [15:0] flash_address;
  logic [7:0]  flash_datain;
  logic        flash_ack;
  logic        diag_halt_req, diag_halt_ack;
  logic        diag_req, diag_we;
  logic [15:0] diag_address;
  logic [7:0]  diag_datain;
  logic        diag_ack;
  logic [15:0] ram_address;
  logic [7:0]  ram_datain;
  logic        ram_cs, ram_we, rdy, data_oe, stalled;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .phi2(phi2), .rwbar(rwbar),
    .cpu_address(cpu_address), .cpu_datain(cpu_datain),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .load_done(load_done),
    .flash_req(flash_req), .flash_we(flash_we),
    .flash_address(flash_address), .flash_datain(flash_datain),
    .flash_ack(flash_ack),
    .diag_halt_req(diag_halt_req), .diag_halt_ack(diag_halt_ack),
    .diag_req(diag_req), .diag_we(diag_we),
    .diag_address(diag_address), .diag_datain(diag_datain),
    .diag_ack(diag_ack),
    .ram_address(ram_address), .ram_datain(ram_datain),
    .ram_cs(ram_cs), .ram_we(ram_we),
    .rdy(rdy), .data_oe(data_oe), .stalled(stalled)
  );

  // External SRAM device
  logic [7:0] sram [0:65535];
  always @(posedge clk)
    if (ram_cs && ram_we) sram[ram_address] = ram_datain;

  // Reference contents of the 0x3000..0x300F window
  logic [7:0] ref_mem [0:15];

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        cs, we, rw;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ecs, ewe, eoe;
  } vec_t;
  vec_t tbl [6];

  logic        rq [L];
  logic        rw [L];
  logic [15:0] ra [L];
  logic [7:0]  rdv [L];
  logic        e_ack [L+3];
  logic        e_cs [L+3];
  logic        e_we [L+3];
  logic        e_rd [L+3];
  logic [15:0] e_addr [L+3];
  logic [7:0]  e_dat [L+3];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_cycle(input logic r);
    rwbar = r;
    phi2  = 1'b1;
    repeat (4) step();
    phi2 = 1'b0;
    repeat (4) step();
  endtask

  task automatic do_access(input logic dg, input logic we,
                           input logic [15:0] a,
                           input logic [7:0] d,
                           input logic chk_rd,
                           input logic [7:0] exp_rd);
    if (dg) begin
      diag_req = 1'b1; diag_we = we;
      diag_address = a; diag_datain = d;
    end else begin
      flash_req = 1'b1; flash_we = we;
      flash_address = a; flash_datain = d;
    end
    step();
    diag_req  = 1'b0;
    flash_req = 1'b0;
    chk("acc_cs", ram_cs, 1);
    chk("acc_we", ram_we, we);
    chk("acc_addr", ram_address, a);
    if (we) chk("acc_data", ram_datain, d);
    chk("acc_early_ack", dg ? diag_ack : flash_ack, 0);
    step();
    chk("acc_ack", dg ? diag_ack : flash_ack, 1);
    chk("acc_other_ack", dg ? flash_ack : diag_ack, 0);
    chk("acc_cs_off", ram_cs, 0);
    if (chk_rd) chk("acc_rdata", sram[ram_address], exp_rd);
    step();
    chk("acc_ack_pulse", dg ? diag_ack : flash_ack, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int last;
    tbl[0] = '{16'h1234, 8'h00, 1'b1, 1'b0, 1'b1,
               16'h1234, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{16'h1234, 8'h00, 1'b1, 1'b0, 1'b0,
               16'h1234, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h0100, 8'h5A, 1'b1, 1'b1, 1'b0,
               16'h0100, 8'h5A, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16'hFFFF, 8'hC3, 1'b0, 1'b0, 1'b1,
               16'hFFFF, 8'hC3, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h0000, 8'hFF, 1'b1, 1'b0, 1'b1,
               16'h0000, 8'hFF, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{16'h8001, 8'h01, 1'b0, 1'b1, 1'b0,
               16'h8001, 8'h01, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 65536; i++) sram[i] = 8'h00;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

    reset = 1'b0; phi2 = 1'b1; rwbar = 1'b1;
    cpu_address = '0; cpu_datain = '0;
    cpu_cs = 1'b0; cpu_we = 1'b0; load_done = 1'b0;
    flash_req = 1'b0; flash_we = 1'b0;
    flash_address = '0; flash_datain = '0;
    diag_halt_req = 1'b0; diag_req = 1'b0; diag_we = 1'b0;
    diag_address = '0; diag_datain = '0;
    #1;
    chk("rst_rdy", rdy, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_stalled", stalled, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_address, 0);
    chk("rst_ram_din", ram_datain, 0);
    chk("rst_flash_ack", flash_ack, 0);
    chk("rst_diag_ack", diag_ack, 0);
    chk("rst_halt_ack", diag_halt_ack, 0);
    repeat (3) step();
    reset = 1'b1;
    step();

    // Diagnostics is not the owner during LOAD
    diag_req = 1'b1; diag_we = 1'b1; diag_address = 16'h0300;
    repeat (4) begin
      step();
      chk("load_diag_ignored", diag_ack, 0);
    end
    diag_req = 1'b0;
    step();

    do_access(1'b0, 1'b1, 16'h0000, 8'hA9, 1'b0, 8'h00);
    do_access(1'b0, 1'b1, 16'h0001, 8'h00, 1'b0, 8'h00);
    do_access(1'b0, 1'b1, 16'hFFFC, 8'h55, 1'b0, 8'h00);
    do_access(1'b0, 1'b0, 16'hFFFC, 8'h00, 1'b1, 8'h55);
    chk("load_rdy_low", rdy, 0);

    load_done = 1'b1;
    step();
    chk("run_rdy", rdy, 1);
    load_done = 1'b0;
    step();
    chk("run_sticky", rdy, 1);

    flash_req = 1'b1; flash_we = 1'b1;
    repeat (4) begin
      step();
      chk("run_flash_ignored", flash_ack, 0);
    end
    flash_req = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cpu_address = tbl[i].a; cpu_datain = tbl[i].d;
      cpu_cs = tbl[i].cs; cpu_we = tbl[i].we; rwbar = tbl[i].rw;
      #1;
      chk("tbl_addr", ram_address, tbl[i].ea);
      chk("tbl_din", ram_datain, tbl[i].ed);
      chk("tbl_cs", ram_cs, tbl[i].ecs);
      chk("tbl_we", ram_we, tbl[i].ewe);
      chk("tbl_oe", data_oe, tbl[i].eoe);
    end
    cpu_cs = 1'b0; cpu_we = 1'b0;

    for (int i = 0; i < 16; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      logic        c, r;
      a = 16'($urandom_range(0, 16'h1FFF));
      d = 8'($urandom);
      c = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      cpu_address = a; cpu_datain = d; cpu_cs = c; rwbar = r;
      #1;
      chk("rnd_addr", ram_address, a);
      chk("rnd_din", ram_datain, d);
      chk("rnd_cs", ram_cs, c);
      chk("rnd_oe", data_oe, c & r);
    end
    cpu_cs = 1'b0;
    step();

    // Halt across two CPU writes and one read
    diag_halt_req = 1'b1;
    step();
    chk("pend_rdy_high", rdy, 1);
    cpu_cycle(1'b0);
    chk("rdy_after_fall", rdy, 0);
    chk("hack_write1", diag_halt_ack, 0);
    cpu_cycle(1'b0);
    chk("hack_write2", diag_halt_ack, 0);
    rwbar = 1'b1; phi2 = 1'b1;
    repeat (4) step();
    chk("hack_before_read", diag_halt_ack, 0);
    phi2 = 1'b0;
    step();
    step();
    chk("hack_at_fall", diag_halt_ack, 0);
    step();
    chk("hack_after_fall", diag_halt_ack, 1);
    chk("halted_rdy", rdy, 0);
    chk("halted_stalled", stalled, 0);
    cpu_cs = 1'b1;
    #1;
    chk("halted_oe", data_oe, 0);
    cpu_cs = 1'b0;
    step();

    do_access(1'b1, 1'b1, 16'h0200, 8'h77, 1'b0, 8'h00);
    do_access(1'b1, 1'b0, 16'h0200, 8'h00, 1'b1, 8'h77);

    // Random diag stream against reference memory and ack timing
    for (int t = 0; t < L; t++) begin
      rq[t]  = ($urandom_range(0, 3) != 0);
      rw[t]  = 1'($urandom_range(0, 1));
      ra[t]  = 16'h3000 + 16'($urandom_range(0, 7));
      rdv[t] = 8'($urandom);
    end
    for (int t = 0; t < L + 3; t++) begin
      e_ack[t] = 1'b0; e_cs[t] = 1'b0; e_we[t] = 1'b0;
      e_rd[t] = 1'b0; e_addr[t] = '0; e_dat[t] = '0;
    end
    last = -3;
    for (int t = 0; t < L; t++) begin
      if (rq[t] && t >= last + 3) begin
        last = t;
        e_cs[t+1]   = 1'b1;
        e_we[t+1]   = rw[t];
        e_addr[t+1] = ra[t];
        e_ack[t+2]  = 1'b1;
        if (rw[t]) ref_mem[ra[t][3:0]] = rdv[t];
        else begin
          e_rd[t+2]  = 1'b1;
          e_dat[t+2] = ref_mem[ra[t][3:0]];
        end
      end
    end
    for (int t = 0; t < L + 3; t++) begin
      if (t < L) begin
        diag_req = rq[t]; diag_we = rw[t];
        diag_address = ra[t]; diag_datain = rdv[t];
      end else diag_req = 1'b0;
      chk("str_ack", diag_ack, e_ack[t]);
      chk("str_cs", ram_cs, e_cs[t]);
      if (e_cs[t]) begin
        chk("str_addr", ram_address, e_addr[t]);
        chk("str_we", ram_we, e_we[t]);
      end
      if (e_rd[t]) chk("str_rdata", sram[ram_address], e_dat[t]);
      step();
    end
    diag_req = 1'b0;

    // Resume
    diag_halt_req = 1'b0;
    step();
    chk("resume_hack", diag_halt_ack, 0);
    chk("resume_rdy_low", rdy, 0);
    cpu_cycle(1'b1);
    chk("resume_rdy", rdy, 1);

    // Watchdog with phi2 frozen low
    diag_halt_req = 1'b1;
    n = 0;
    while (!diag_halt_ack && n < 40) begin
      step();
      n++;
    end
    chk("wd_cycles", n, 17);
    chk("wd_stalled", stalled, 1);
    chk("wd_rdy", rdy, 0);
    diag_halt_req = 1'b0;
    step();
    chk("wd_stalled_hold", stalled, 1);
    cpu_cycle(1'b1);
    chk("wd_run_rdy", rdy, 1);
    chk("wd_stalled_clear", stalled, 0);

    // Reset in cycle N+1 of a diag access
    diag_halt_req = 1'b1;
    cpu_cycle(1'b1);
    cpu_cycle(1'b1);
    chk("rehalt_hack", diag_halt_ack, 1);
    diag_req = 1'b1; diag_we = 1'b1;
    diag_address = 16'h0300; diag_datain = 8'hEE;
    step();
    chk("mid_cs", ram_cs, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_cs", ram_cs, 0);
    chk("mid_rst_addr", ram_address, 0);
    chk("mid_rst_rdy", rdy, 0);
    chk("mid_rst_hack", diag_halt_ack, 0);
    chk("mid_rst_dack", diag_ack, 0);
    diag_req = 1'b0;
    repeat (3) begin
      step();
      chk("mid_rst_no_ack", diag_ack, 0);
    end
    reset = 1'b1;
    step();
    chk("mid_rst_no_ack2", diag_ack, 0);
    chk("mid_rst_no_write", sram[16'h0300], 0);

    // Back in LOAD: flash owns the RAM, halt request waits
    do_access(1'b0, 1'b1, 16'h0400, 8'h12, 1'b0, 8'h00);
    chk("reload_rdy", rdy, 0);
    chk("reload_hack", diag_halt_ack, 0);
    load_done = 1'b1;
    step();
    chk("reload_run_rdy", rdy, 1);
    load_done = 1'b0;
    step();
    n = 0;
    while (!diag_halt_ack && n < 40) begin
      step();
      n++;
    end
    chk("held_halt_wd", n, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
